// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell time-shared LSB first over WIDTH cycles.
// Start is accepted only in IDLE; Sum/Carry_out update on the edge that finishes bit WIDTH-1.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:1] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;
    logic             busy_next;
    logic             done_next;

    // The single full-adder cell
    assign fa_sum   = opa[0] ^ opb[0] ^ carry;
    assign fa_carry = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // Result shifts in at the MSB; the bit that falls off the bottom is never needed
    assign res_next = {fa_sum, res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they can be registered
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        if (state_next != IDLE) busy_next = 1'b1;
        if (state_next == DONE) done_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                opa   <= a;
                opb   <= b;
                carry <= carry_in;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            opa   <= {1'b0, opa[WIDTH-1:1]};
            opb   <= {1'b0, opb[WIDTH-1:1]};
            carry <= fa_carry;
            res   <= res_next[WIDTH-1:1];
            if (last_bit) begin
                sum       <= res_next;
                carry_out <= fa_carry;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_serial_adder_ctrl;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        co8;
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        co16;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t e8;
    exp_t e16;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per Done pulse and compare value and timing
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 64'(sum8), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e8 = q8.pop_front();
                check("result8", {55'd0, co8, sum8}, e8.val);
                check("done_cycle8", 64'(cyc), 64'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 64'(sum16), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e16 = q16.pop_front();
                check("result16", {47'd0, co16, sum16}, e16.val);
                check("done_cycle16", 64'(cyc), 64'(e16.cyc));
            end
        end
    end

    // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle again
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [8:0] exp);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        q8.push_back('{64'(exp), cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            check("busy8_high", 64'(busy8), 64'd1);
            @(negedge clk);
        end
        check("busy8_low", 64'(busy8), 64'd0);
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
        q16.push_back('{64'({1'b0, a} + {1'b0, b} + 17'(cin)), cyc + 1 + 16});
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        repeat (17) @(negedge clk);
    endtask

    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         k;

    initial begin
        // Reset state
        #2;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_co", 64'(co8), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed {carry_out, sum}
        go8(8'h5A, 8'h3C, 1'b0, 9'h096);
        go8(8'hFF, 8'h01, 1'b0, 9'h100);
        go8(8'hFF, 8'h00, 1'b1, 9'h100);
        go8(8'h00, 8'h00, 1'b0, 9'h000);
        go8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        go8(8'hAA, 8'h55, 1'b1, 9'h100);
        go8(8'h0F, 8'h01, 1'b0, 9'h010);

        // Start during RUN is ignored
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{64'h002, cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hF0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_start_sum", 64'(sum8), 64'h02);

        // Start held high: accepted every WIDTH+2 cycles
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        k = cyc + 1;
        q8.push_back('{64'h030, k + 8});
        q8.push_back('{64'h030, k + 18});
        q8.push_back('{64'h030, k + 28});
        repeat (30) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Results hold through the next RUN, then reset abandons the operation
        go8(8'h12, 8'h34, 1'b0, 9'h046);
        check("sum_after_0x12_0x34", 64'(sum8), 64'h46);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("sum_held_in_run", 64'(sum8), 64'h46);
        check("busy_in_run", 64'(busy8), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy8), 64'd0);
        check("async_rst_done", 64'(done8), 64'd0);
        check("async_rst_sum", 64'(sum8), 64'd0);
        check("async_rst_co", 64'(co8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        go8(8'h01, 8'h02, 1'b1, 9'h004);

        // Random regression against a reference adder, both widths
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            go8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc));
        end
        for (int i = 0; i < 1000; i++) begin
            go16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'd0);
        check("q16_drained", 64'(q16.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 A  input  WIDTH  first operand; sampled on the edge that accepts Start.
REQ-006 B  input  WIDTH  second operand; sampled on the edge that accepts Start.
REQ-007 Carry_in  input  1  initial carry; sampled on the edge that accepts Start.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  single-cycle completion pulse.
REQ-010 Sum  output  WIDTH  registered result of the last completed addition.
REQ-011 Carry_out  output  1  registered carry of the last completed addition.

Function
REQ-012 The block SHALL contain exactly one single-bit full-adder cell and SHALL time-share it, one bit per cycle, LSB first.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE, encoded in 2 bits.
REQ-014 IDLE -> RUN SHALL occur on an edge with Start=1, latching A and B into shift registers, Carry_in into the carry register, and clearing the bit counter.
REQ-015 In RUN, each edge SHALL compute the sum of opA[0] + opB[0] + carry, shift the sum bit into the MSB of the result shift register, shift both operand registers right, update the carry register, and increment the counter.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1; on that same edge, Sum SHALL load the completed result and Carry_out SHALL load the final carry.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 Done SHALL be high only in DONE: exactly one cycle per operation.
REQ-019 Timing: if Start is accepted at edge k, Done SHALL be high from edge k+WIDTH to edge k+WIDTH+1, and Busy SHALL be high from edge k to edge k+WIDTH+1.
REQ-020 Start in RUN or DONE SHALL be ignored, with no queuing; A, B and Carry_in changes while Busy SHALL NOT affect the result.
REQ-021 If Start is held high continuously, successive operations SHALL be accepted at edges k, k+WIDTH+2, k+2(WIDTH+2), and so on.
REQ-022 Sum and Carry_out SHALL hold their values between completions, including throughout the next operation's RUN state.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH: {Carry_out, Sum} = A + B + Carry_in, with no overflow flag.
REQ-024 The counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap in RUN, because the exit occurs at count WIDTH-1.

Reset
REQ-025 Rst_n=0 SHALL immediately force state to IDLE and drive Busy=0, Done=0, Sum=0 and Carry_out=0, and clear the operand registers, carry register and counter, without waiting for a clock edge.
REQ-026 Reset asserted mid-operation SHALL abandon the operation: no Done pulse, and Sum and Carry_out become 0.
REQ-027 After Rst_n rises, the first edge with Start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=8, A=0x5A, B=0x3C, Carry_in=0, 1-cycle Start -> Done pulse at edge k+8, Sum=0x96, Carry_out=0, Busy high for 9 cycles.
REQ-029 A=0xFF, B=0x01, Carry_in=0 -> Sum=0x00, Carry_out=1. A=0xFF, B=0x00, Carry_in=1 -> Sum=0x00, Carry_out=1.
REQ-030 Start with A=0x01, B=0x01; at edge k+3 pulse Start with A=0xF0 -> ignored, Sum=0x02 at Done, and no second Done follows.
REQ-031 Start held high for 30 cycles with A=0x10, B=0x20 -> Done pulses at edges k+8, k+18 and k+28, and Sum=0x30 each time.
REQ-032 Complete 0x12+0x34 to get Sum=0x46, then start 0x80+0x80 and assert Rst_n=0 at edge k+4 -> Busy, Sum and Carry_out go 0 asynchronously, with no Done pulse.
REQ-033 Random regression: at least 1000 random A, B and Carry_in values at WIDTH=8 and WIDTH=16 -> {Carry_out, Sum} matches a reference adder at every Done.
